// File: rtl/instr_fetch_if.sv
// Instruction-memory request/response bus between the fetch unit and memory.
// The fetch unit drives req/addr. Memory drives gnt and returns in-order
// responses (rvalid/rdata).
interface instr_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch unit. The unit keeps up to two reads in flight to
// instruction memory and buffers returned words in a 3-entry FIFO of
// {pc, instr}. A redirect (PCSrc) flushes the buffer. Responses still in
// flight when the redirect happens are counted in kill and dropped on return.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          reset,
  instr_fetch_if.master imem,
  input  logic          PCSrc,
  input  logic [31:0]   BranchTarget,
  output logic [31:0]   Instr,
  output logic          InstrValid,
  input  logic          InstrReady,
  output logic [31:0]   PC,
  output logic [31:0]   PCPlus8
);

  localparam logic [31:0] START_PC = RESET_PC & 32'hFFFF_FFFC;

  typedef enum logic {RUN, FLUSH} state_t;

  state_t      state_reg, state_next;
  logic [31:0] fetch_pc_reg, fetch_pc_next;
  logic [31:0] resp_pc_reg, resp_pc_next;
  logic [1:0]  outstanding_reg, outstanding_next;
  logic [1:0]  kill_reg, kill_next;
  logic [1:0]  count_reg, count_next;
  logic [1:0]  wr_ptr_reg, wr_ptr_next;
  logic [1:0]  rd_ptr_reg, rd_ptr_next;

  logic [31:0] fifo_pc    [0:2];
  logic [31:0] fifo_instr [0:2];

  logic        grant, any_resp, live_resp, killed_resp, enq, deq;
  logic [31:0] target, head_pc, head_instr;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  assign target     = BranchTarget & 32'hFFFF_FFFC;
  assign InstrValid = (count_reg != 2'd0);

  // The credit check (in-flight + buffered < 3) guarantees that every granted
  // read has a free FIFO slot when it returns. The reset term holds the
  // request low while reset is asserted and lets the first request go out in
  // the first cycle after release.
  assign imem.imem_req  = reset && (state_reg == RUN) && (outstanding_reg < 2'd2) &&
                          (({1'b0, outstanding_reg} + {1'b0, count_reg}) < 3'd3);
  assign imem.imem_addr = fetch_pc_reg;

  assign grant       = imem.imem_req && imem.imem_gnt;
  assign any_resp    = imem.imem_rvalid && (outstanding_reg != 2'd0);
  assign killed_resp = any_resp && (kill_reg != 2'd0);
  assign live_resp   = any_resp && (kill_reg == 2'd0);
  // A redirect discards both the incoming word and the head entry.
  assign enq         = live_resp && !PCSrc;
  assign deq         = InstrValid && InstrReady && !PCSrc;

  // Next-state values for the counters, fetch/response PCs and FIFO pointers.
  always_comb begin
    outstanding_next = outstanding_reg;
    kill_next        = kill_reg;
    fetch_pc_next    = fetch_pc_reg;
    resp_pc_next     = resp_pc_reg;
    count_next       = count_reg;
    wr_ptr_next      = wr_ptr_reg;
    rd_ptr_next      = rd_ptr_reg;

    if (grant && !any_resp) begin
      outstanding_next = outstanding_reg + 2'd1;
    end else if (!grant && any_resp) begin
      outstanding_next = outstanding_reg - 2'd1;
    end

    if (killed_resp) begin
      kill_next = kill_reg - 2'd1;
    end
    // In RUN, every read still in flight after this edge belongs to the old
    // path. This includes a read granted this cycle but not one that returns
    // this cycle. In FLUSH, every read in flight is already counted in kill.
    if (PCSrc && (state_reg == RUN)) begin
      kill_next = outstanding_next;
    end

    if (PCSrc) begin
      fetch_pc_next = target;
      resp_pc_next  = target;
      count_next    = 2'd0;
      wr_ptr_next   = 2'd0;
      rd_ptr_next   = 2'd0;
    end else begin
      if (grant)     fetch_pc_next = fetch_pc_reg + 32'd4;
      if (live_resp) resp_pc_next  = resp_pc_reg + 32'd4;
      if (enq)       wr_ptr_next   = ptr_inc(wr_ptr_reg);
      if (deq)       rd_ptr_next   = ptr_inc(rd_ptr_reg);
      if (enq && !deq) begin
        count_next = count_reg + 2'd1;
      end else if (!enq && deq) begin
        count_next = count_reg - 2'd1;
      end
    end
  end

  // FSM next state: enter FLUSH while old-path reads remain, leave when none are left.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RUN:     if (PCSrc && (kill_next != 2'd0)) state_next = FLUSH;
      FLUSH:   if (kill_next == 2'd0)            state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  // State and control registers. Reset abandons any reads still in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg       <= RUN;
      fetch_pc_reg    <= START_PC;
      resp_pc_reg     <= START_PC;
      outstanding_reg <= 2'd0;
      kill_reg        <= 2'd0;
      count_reg       <= 2'd0;
      wr_ptr_reg      <= 2'd0;
      rd_ptr_reg      <= 2'd0;
    end else begin
      state_reg       <= state_next;
      fetch_pc_reg    <= fetch_pc_next;
      resp_pc_reg     <= resp_pc_next;
      outstanding_reg <= outstanding_next;
      kill_reg        <= kill_next;
      count_reg       <= count_next;
      wr_ptr_reg      <= wr_ptr_next;
      rd_ptr_reg      <= rd_ptr_next;
    end
  end

  // FIFO storage. The slots need no reset because count_reg marks which slots are valid.
  for (genvar gi = 0; gi < 3; gi++) begin : g_slot
    // Write slot gi when it is the enqueue target.
    always_ff @(posedge clk) begin
      if (enq && (wr_ptr_reg == 2'(gi))) begin
        fifo_pc[gi]    <= resp_pc_reg;
        fifo_instr[gi] <= imem.imem_rdata;
      end
    end
  end

  // Read the head entry.
  always_comb begin
    head_pc    = fifo_pc[2];
    head_instr = fifo_instr[2];
    case (rd_ptr_reg)
      2'd0: begin
        head_pc    = fifo_pc[0];
        head_instr = fifo_instr[0];
      end
      2'd1: begin
        head_pc    = fifo_pc[1];
        head_instr = fifo_instr[1];
      end
      default: begin
        head_pc    = fifo_pc[2];
        head_instr = fifo_instr[2];
      end
    endcase
  end

  // When the buffer is empty, PC shows the address the next instruction will have.
  assign Instr   = InstrValid ? head_instr : 32'd0;
  assign PC      = InstrValid ? head_pc : resp_pc_reg;
  assign PCPlus8 = PC + 32'd8;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed testbench for instr_fetch. The memory model returns responses in
// order with a latency of 1, 2 or 3 cycles. Each memory word is a fixed
// function of its address. Every delivered instruction is checked against the
// expected sequential PC stream.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        PCSrc;
  logic [31:0] BranchTarget;
  logic [31:0] Instr;
  logic        InstrValid;
  logic        InstrReady;
  logic [31:0] PC;
  logic [31:0] PCPlus8;

  instr_fetch_if bus ();

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .reset        (reset),
    .imem         (bus),
    .PCSrc        (PCSrc),
    .BranchTarget (BranchTarget),
    .Instr        (Instr),
    .InstrValid   (InstrValid),
    .InstrReady   (InstrReady),
    .PC           (PC),
    .PCPlus8      (PCPlus8)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          n_deliv  = 0;
  int          lat      = 1;
  bit          track    = 1'b0;
  logic [31:0] exp_pc   = 32'd0;

  logic [2:0]  st_v = 3'b000;
  logic [31:0] st_a [0:2];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  // In-order memory with selectable latency.
  always @(posedge clk) begin
    st_v    <= {st_v[1:0], bus.imem_req & bus.imem_gnt};
    st_a[0] <= bus.imem_addr;
    st_a[1] <= st_a[0];
    st_a[2] <= st_a[1];
  end

  assign bus.imem_rvalid = (lat == 1) ? st_v[0] : (lat == 2) ? st_v[1] : st_v[2];
  assign bus.imem_rdata  = (lat == 1) ? mem_word(st_a[0]) :
                           (lat == 2) ? mem_word(st_a[1]) : mem_word(st_a[2]);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("  ok   %s = 0x%08h", tag, got);
    end
  endtask

  // Advance one clock. Before the edge, check the head if it will be consumed.
  task automatic cyc();
    if (track && InstrValid && InstrReady && !PCSrc) begin
      check("deliver_pc", PC, exp_pc);
      check("deliver_instr", Instr, mem_word(exp_pc));
      check("deliver_pc_plus8", PCPlus8, exp_pc + 32'd8);
      exp_pc = exp_pc + 32'd4;
      n_deliv++;
    end
    @(negedge clk);
  endtask

  task automatic consume(input int n, input int budget);
    int start;
    int k;
    start = n_deliv;
    k = 0;
    while ((n_deliv - start) < n && k < budget) begin
      cyc();
      k++;
    end
    check("delivery_count", n_deliv - start, n);
  endtask

  // Stop granting and let everything in flight and buffered drain out.
  task automatic drain();
    bus.imem_gnt = 1'b0;
    InstrReady   = 1'b1;
    repeat (5) cyc();
    check("drain_valid", InstrValid, 1'b0);
    check("drain_addr", bus.imem_addr, exp_pc);
  endtask

  // Redirect from steady state: one read is granted and one returns in the same cycle.
  task automatic redirect(input logic [31:0] tgt, input logic [31:0] aligned);
    check("redir_rvalid_pre", bus.imem_rvalid, 1'b1);
    check("redir_req_pre", bus.imem_req, 1'b1);
    PCSrc        = 1'b1;
    BranchTarget = tgt;
    cyc();
    PCSrc = 1'b0;
    check("redir_valid_flushed", InstrValid, 1'b0);
    check("redir_req_flush", bus.imem_req, 1'b0);
    check("redir_addr", bus.imem_addr, aligned);
    cyc();
    check("redir_req_run", bus.imem_req, 1'b1);
    check("redir_addr_run", bus.imem_addr, aligned);
    exp_pc = aligned;
  endtask

  initial begin
    reset        = 1'b0;
    PCSrc        = 1'b0;
    BranchTarget = 32'd0;
    InstrReady   = 1'b1;
    bus.imem_gnt = 1'b1;
    repeat (2) @(negedge clk);

    // Values held during reset.
    check("rst_req", bus.imem_req, 1'b0);
    check("rst_addr", bus.imem_addr, 32'h0);
    check("rst_valid", InstrValid, 1'b0);
    check("rst_instr", Instr, 32'h0);
    check("rst_pc", PC, 32'h0);
    check("rst_pc_plus8", PCPlus8, 32'h8);

    // After release, the first request goes out immediately. InstrValid rises two cycles after the grant.
    reset = 1'b1;
    #1;
    check("first_req", bus.imem_req, 1'b1);
    check("first_addr", bus.imem_addr, 32'h0);
    cyc();
    check("lat_valid_n1", InstrValid, 1'b0);
    check("lat_addr_n1", bus.imem_addr, 32'h4);
    cyc();
    check("lat_valid_n2", InstrValid, 1'b1);
    track  = 1'b1;
    exp_pc = 32'h0;
    consume(6, 12);

    // Stall the consumer for 5 cycles. The buffer fills to 3 and requests stop.
    InstrReady = 1'b0;
    repeat (5) cyc();
    check("stall_req", bus.imem_req, 1'b0);
    check("stall_valid", InstrValid, 1'b1);
    check("stall_head_pc", PC, exp_pc);
    check("stall_fetch_addr", bus.imem_addr, exp_pc + 32'd12);
    InstrReady = 1'b1;
    consume(8, 30);

    // Redirect with two reads in flight and none returning. Both responses are killed.
    drain();
    lat          = 3;
    bus.imem_gnt = 1'b1;
    cyc();
    cyc();
    check("two_out_req", bus.imem_req, 1'b0);
    check("two_out_rvalid", bus.imem_rvalid, 1'b0);
    PCSrc        = 1'b1;
    BranchTarget = 32'h0000_0100;
    cyc();
    PCSrc = 1'b0;
    check("br_valid", InstrValid, 1'b0);
    check("br_req_flush0", bus.imem_req, 1'b0);
    check("br_addr", bus.imem_addr, 32'h100);
    cyc();
    check("br_req_flush1", bus.imem_req, 1'b0);
    cyc();
    check("br_req_run", bus.imem_req, 1'b1);
    check("br_addr_run", bus.imem_addr, 32'h100);
    lat    = 1;
    exp_pc = 32'h100;
    consume(4, 20);

    // Redirect in the same cycle as a grant and a response, with an unaligned target.
    redirect(32'h0000_0203, 32'h0000_0200);
    consume(3, 20);

    // Redirect near the top of the address space. The fetch address wraps to 0.
    redirect(32'hFFFF_FFF8, 32'hFFFF_FFF8);
    consume(4, 20);

    // Pulse reset with two reads in flight. Their late responses must be ignored.
    drain();
    lat          = 2;
    InstrReady   = 1'b0;
    bus.imem_gnt = 1'b1;
    cyc();
    cyc();
    check("pre_rst_req", bus.imem_req, 1'b0);
    reset = 1'b0;
    #1;
    check("mid_rst_req", bus.imem_req, 1'b0);
    check("mid_rst_addr", bus.imem_addr, 32'h0);
    check("mid_rst_valid", InstrValid, 1'b0);
    bus.imem_gnt = 1'b0;
    reset        = 1'b1;
    #1;
    check("post_rst_req", bus.imem_req, 1'b1);
    InstrReady = 1'b1;
    exp_pc     = 32'h0;
    repeat (3) begin
      cyc();
      check("stale_valid", InstrValid, 1'b0);
      check("stale_addr", bus.imem_addr, 32'h0);
    end
    lat          = 1;
    bus.imem_gnt = 1'b1;
    consume(4, 20);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 Port clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port reset  in  1  SHALL be asynchronous, active-low; reset=0 clears all state immediately.
REQ-004 Port PCSrc  in  1  SHALL be the redirect strobe from the controller (taken branch or PC write).
REQ-005 Port BranchTarget  in  32  SHALL be the redirect address, sampled when PCSrc=1.
REQ-006 Port imem_req  out  1  SHALL request an instruction-memory read at imem_addr.
REQ-007 Port imem_addr  out  32  SHALL be the fetch address, word aligned (bits [1:0]=0).
REQ-008 Port imem_gnt  in  1  SHALL indicate memory accepted the request this cycle (counts only when imem_req=1).
REQ-009 Port imem_rvalid  in  1  SHALL mark a read response, returned in request order, latency >=1 cycle.
REQ-010 Port imem_rdata  in  32  SHALL be the response word, valid with imem_rvalid.
REQ-011 Port Instr  out  32  SHALL be the head buffered instruction; 0 when InstrValid=0.
REQ-012 Port InstrValid  out  1  SHALL indicate Instr/PC are valid.
REQ-013 Port InstrReady  in  1  SHALL indicate the controller consumes the head this cycle.
REQ-014 Port PC  out  32  SHALL be the address of Instr; PCPlus8  out  32  SHALL equal PC+8 (mod 2^32).

Function
REQ-015 States: RUN, FLUSH; reset enters RUN.
REQ-016 Registers: fetch_pc (32), resp_pc (32), outstanding (0..2), kill (0..2), 3-entry FIFO of {pc, instr}.
REQ-017 imem_req = (state==RUN) && outstanding<2 && outstanding+count<3, from registered values only; imem_addr = fetch_pc.
REQ-018 Grant (imem_req && imem_gnt) SHALL increment outstanding and set fetch_pc = fetch_pc+4, wrapping at 2^32.
REQ-019 Live response (imem_rvalid && kill==0 && outstanding>0) SHALL enqueue {resp_pc, imem_rdata}, set resp_pc += 4, and decrement outstanding.
REQ-020 Killed response (imem_rvalid && kill>0) SHALL be discarded and SHALL decrement kill and outstanding.
REQ-021 imem_rvalid with outstanding==0 SHALL be ignored.
REQ-022 Dequeue on InstrValid && InstrReady; enqueue and dequeue in the same cycle SHALL both occur, count unchanged.
REQ-023 Credit rule guarantees the FIFO never overflows; an enqueue into a full FIFO is a design error and is not handled.
REQ-024 PCSrc=1 SHALL, next edge: flush the FIFO (InstrValid=0); set fetch_pc and resp_pc to {BranchTarget[31:2],2'b00}; set kill to the post-edge outstanding count, including a grant and excluding a response in the same cycle.
REQ-025 A PCSrc cycle SHALL move to FLUSH if the resulting kill>0, else stay in RUN; FLUSH SHALL return to RUN when kill reaches 0.
REQ-026 PCSrc in FLUSH SHALL update fetch_pc/resp_pc again and keep the current kill count.
REQ-027 PCSrc takes priority over dequeue: a same-cycle InstrReady has no effect on the flushed entries.
REQ-028 Throughput: with 1-cycle memory, always-granted, and InstrReady=1, the block SHALL deliver one instruction per cycle in steady state.
REQ-029 Fetch-to-InstrValid latency with 1-cycle memory: request granted at cycle n -> InstrValid at cycle n+2.

Reset
REQ-030 While reset=0: imem_req=0, imem_addr=RESET_PC, InstrValid=0, Instr=0, PC=RESET_PC, PCPlus8=RESET_PC+8; outstanding=kill=0; FIFO empty; state RUN.
REQ-031 Reset asserted mid-transaction SHALL abandon in-flight requests; their responses after release fall under REQ-021.
REQ-032 First imem_req SHALL assert in the first cycle after reset deasserts.

Verification
REQ-033 Reset release, 1-cycle memory, gnt=1, InstrReady=1 -> addresses 0,4,8,... issued; InstrValid from cycle 2; PC 0,4,8 with matching Instr.
REQ-034 InstrReady=0 for 5 cycles -> at most 3 entries buffered; imem_req drops; no lost or duplicated instruction after release.
REQ-035 PCSrc=1, BranchTarget=0x100, two requests outstanding -> both responses dropped; next Instr has PC=0x100; state FLUSH then RUN.
REQ-036 PCSrc in the same cycle as imem_gnt and imem_rvalid -> granted request killed; returned word dropped; kill=1.
REQ-037 fetch_pc=0xFFFF_FFFC granted -> next imem_addr=0x0000_0000; PCPlus8 for PC 0xFFFF_FFFC = 0x0000_0004.
REQ-038 reset pulsed low with 2 outstanding, then stale imem_rvalid after release -> ignored; fetch restarts at RESET_PC.
